// File: rtl/audio_pkg.sv
// Shared audio definitions: sample/frame widths, DAC power-down codes,
// serializer state encoding and the DAC frame-word builder.
package audio_pkg;

    localparam int AUDIO_W     = 12;
    localparam int DAC_FRAME_W = 16;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } dac_state_t;

    // Two don't-care zeros, the power-down code, then the raw sample.
    function automatic logic [DAC_FRAME_W-1:0] dac_frame_word(
        input logic [1:0]         pd,
        input logic [AUDIO_W-1:0] sample
    );
        return {2'b00, pd, sample};
    endfunction

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Sample input and DAC pin bundle for the audio DAC serializer.
// tick_force lets a host inject extra sample ticks on top of the internal
// divider; tie it low in normal use.
interface audio_dac_serializer_if;
    import audio_pkg::*;

    logic [AUDIO_W-1:0] audio_in;
    logic               tick_force;
    logic               dac_sync;
    logic               dac_sclk;
    logic               dac_d;
    logic               busy;
    logic               sample_strobe;
    logic               overrun;

    modport master (
        input  audio_in,
        input  tick_force,
        output dac_sync,
        output dac_sclk,
        output dac_d,
        output busy,
        output sample_strobe,
        output overrun
    );

    modport slave (
        output audio_in,
        output tick_force,
        input  dac_sync,
        input  dac_sclk,
        input  dac_d,
        input  busy,
        input  sample_strobe,
        input  overrun
    );

endinterface

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// The tick is high while the counter sits at DIV-1.
module sample_tick_gen #(
    parameter int DIV = 5000
) (
    input  logic clk100M,
    input  logic rstn,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    // Count 0..DIV-1 and wrap; reset parks the counter at zero.
    always_ff @(posedge clk100M) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DIV - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == CW'(DIV - 1));

endmodule

// File: rtl/audio_dac_serializer.sv
// Serialises one 16-bit DAC121S101 frame per audio sample tick.
// A tick accepted in IDLE latches audio_in and pulses sample_strobe; the next
// cycle drops SYNC and presents bit 15. SCLK toggles every SCLK_HALF clocks,
// data advances on rising SCLK so it is stable around each falling edge.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int         CLK_HZ    = 100_000_000,
    parameter int         SAMPLE_HZ = 20_000,
    parameter int         SCLK_HALF = 2,
    parameter logic [1:0] PD_MODE   = PD_NORMAL
) (
    input  logic                   clk100M,
    input  logic                   rstn,
    audio_dac_serializer_if.master bus
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int HW  = $clog2(SCLK_HALF) + 1;

    // A frame plus its start cycle must fit inside one tick period.
    generate
        if (DIV <= 32 * SCLK_HALF + 2) begin : g_div_check
            $error("audio_dac_serializer: DIV must exceed 32*SCLK_HALF+2");
        end
    endgenerate

    logic                   w_tick_int;
    logic                   w_tick;
    logic                   w_hwrap;
    logic                   w_end;
    logic                   w_accept;

    dac_state_t             r_state;
    logic                   r_load;
    logic [HW-1:0]          r_hcnt;
    logic [4:0]             r_bitcnt;
    logic [DAC_FRAME_W-1:0] r_shift;
    logic                   r_sync;
    logic                   r_busy;
    logic                   r_sclk;
    logic                   r_d;
    logic                   r_strobe;
    logic                   r_overrun;

    sample_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk100M (clk100M),
        .rstn    (rstn),
        .tick    (w_tick_int)
    );

    assign w_tick   = w_tick_int | bus.tick_force;
    assign w_hwrap  = (r_hcnt == HW'(SCLK_HALF - 1));
    // Last half-period of a frame: the closing SCLK rise after bit 16 fell.
    assign w_end    = (r_state == SHIFT) && !r_load && w_hwrap && !r_sclk &&
                      (r_bitcnt == 5'd16);
    assign w_accept = w_tick && ((r_state == IDLE) || w_end);

    // Frame FSM, SCLK divider, bit counter and shift register.
    always_ff @(posedge clk100M) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_load    <= 1'b0;
            r_hcnt    <= '0;
            r_bitcnt  <= 5'd0;
            r_shift   <= '0;
            r_sync    <= 1'b1;
            r_busy    <= 1'b0;
            r_sclk    <= 1'b1;
            r_d       <= 1'b0;
            r_strobe  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_strobe  <= w_accept;
            r_overrun <= w_tick && (r_state == SHIFT) && !w_end;
            case (r_state)
                IDLE: begin
                    r_sync   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_sclk   <= 1'b1;
                    r_d      <= 1'b0;
                    r_hcnt   <= '0;
                    r_bitcnt <= 5'd0;
                    if (w_tick) begin
                        r_shift <= dac_frame_word(PD_MODE, bus.audio_in);
                        r_load  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_load  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (r_load) begin
                        // Open the frame with bit 15 on the line.
                        r_load   <= 1'b0;
                        r_sync   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_sclk   <= 1'b1;
                        r_d      <= r_shift[DAC_FRAME_W-1];
                        r_shift  <= {r_shift[DAC_FRAME_W-2:0], 1'b0};
                        r_hcnt   <= '0;
                        r_bitcnt <= 5'd0;
                    end else if (w_hwrap) begin
                        r_hcnt <= '0;
                        if (r_sclk) begin
                            r_sclk   <= 1'b0;
                            r_bitcnt <= r_bitcnt + 5'd1;
                        end else if (r_bitcnt == 5'd16) begin
                            r_sync   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_sclk   <= 1'b1;
                            r_d      <= 1'b0;
                            r_bitcnt <= 5'd0;
                            if (w_tick) begin
                                r_shift <= dac_frame_word(PD_MODE, bus.audio_in);
                                r_load  <= 1'b1;
                                r_state <= SHIFT;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_sclk  <= 1'b1;
                            r_d     <= r_shift[DAC_FRAME_W-1];
                            r_shift <= {r_shift[DAC_FRAME_W-2:0], 1'b0};
                        end
                    end else begin
                        r_hcnt <= r_hcnt + HW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_load  <= 1'b0;
                    r_sync  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_sclk  <= 1'b1;
                    r_d     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dac_sync      = r_sync;
    assign bus.dac_sclk      = r_sclk;
    assign bus.dac_d         = r_d;
    assign bus.busy          = r_busy;
    assign bus.sample_strobe = r_strobe;
    assign bus.overrun       = r_overrun;

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Consumes the 12-bit `audio_out` sample stream produced by the audio tasks and drives it to the board's Pmod DA2-style DAC (DAC121S101, 16-bit SPI-like frame). It samples `audio_in` at a fixed audio rate and serialises one frame per sample. It sits between the audio mux and the Pmod pins as the sole owner of the DAC interface.

## Interface
- `CLK_HZ`, 100_000_000, frequency of `clk100M` in Hz
- `SAMPLE_HZ`, 20_000, DAC update rate; tick period `DIV = CLK_HZ/SAMPLE_HZ` = 5000 cycles
- `SCLK_HALF`, 2, `clk100M` cycles per SCLK half-period (SCLK = 25 MHz at default)
- `PD_MODE`, 2'b00, DAC power-down bits sent in frame bits [13:12]; 00 is normal operation
- `clk100M` in 1: system clock. One clock only. Reset is synchronous and active-low.
- `rstn` in 1: synchronous active-low reset
- `audio_in` in 12: unsigned sample, latched only on the sample tick
- `dac_sync` out 1: frame select, active low
- `dac_sclk` out 1: serial clock, idles high
- `dac_d` out 1: serial data; the DAC samples it on the SCLK falling edge
- `busy` out 1: high while a frame is in progress; equals `~dac_sync`
- `sample_strobe` out 1: one-cycle pulse on the cycle `audio_in` is latched
- `overrun` out 1: one-cycle pulse when a tick arrives while `busy`

## Operation
- Reset values, with `rstn` low at a clock edge: `dac_sync`=1, `dac_sclk`=1, `dac_d`=0, `busy`=0, `sample_strobe`=0, `overrun`=0, tick counter=0, state IDLE.
- Reset mid-frame aborts the frame. All outputs take their reset values on the next edge, and no partial-frame completion occurs.
- Tick counter counts 0..DIV-1 and wraps. The tick is asserted for the one cycle when the counter equals DIV-1.
- Frame word is {2'b00, PD_MODE, audio_in}: 16 bits, sent MSB first.
- State IDLE:
  - Outputs are held idle.
  - On tick: latch the frame word, pulse `sample_strobe`, go to SHIFT.
- State SHIFT:
  - `dac_sync`=0. A half-period counter runs 0..SCLK_HALF-1.
  - At each wrap, `dac_sclk` toggles.
  - On each low-to-high toggle, the shift register advances and `dac_d` presents the next bit.
  - A bit counter counts the 16 falling edges.
  - After the 16th falling edge plus one more half-period, `dac_sclk` returns high and the block goes to IDLE, with `dac_sync`=1 and `dac_d`=0 in the same cycle.
- Overrun:
  - A tick seen while in SHIFT is dropped.
  - `overrun` pulses on that tick cycle.
  - The frame in flight is unaffected, and the tick counter keeps running.
- Tick in the same cycle as the return to IDLE: that cycle's tick is accepted as a new frame.
- Arithmetic:
  - Tick counter width is $clog2(DIV).
  - Bit counter is 5 bits, counting to 16.
  - Half-period counter width is $clog2(SCLK_HALF)+1.
  - No sign handling: `audio_in` is passed through unmodified.
- Elaboration-time check: DIV > 32*SCLK_HALF + 2. Elaboration fails otherwise.

## Timing
- With the tick at cycle T, and H = SCLK_HALF:
  - T: `sample_strobe`=1; `audio_in` is sampled at this edge.
  - T+1: `dac_sync`=0, `dac_sclk`=1, `dac_d`=bit15.
  - Falling SCLK at T+1+H·(2k+1), for k=0..15. `dac_d` is stable for H cycles on each side of every falling edge.
  - Rising SCLK, with `dac_d` updated to bit(14-k), at T+1+H·(2k+2), for k=0..14.
  - End of frame at T+1+32H: `dac_sync`=1, `dac_sclk`=1, `dac_d`=0.
- `dac_sync` is low for exactly 32H cycles (64 at default).
- Latency from `audio_in` capture to the DAC latching the last bit is 1+31H cycles.
- First tick after reset release occurs DIV-1 cycles after the first cycle with `rstn`=1.
- All outputs are registered. There is no combinational path from `audio_in` to any pin.

## Structure
- Shared package `audio_pkg`:
  - `AUDIO_W`=12
  - `DAC_FRAME_W`=16
  - PD mode constants: `PD_NORMAL`=2'b00, `PD_1K`=2'b01, `PD_100K`=2'b10, `PD_HIZ`=2'b11
  - State enum {IDLE, SHIFT}
- One sub-module: `sample_tick_gen` (parameter DIV; ports `clk100M`, `rstn`, `tick`). It is reusable by the other audio blocks.
- The frame FSM, shift register and SCLK divider live in the top module.

## Test plan
- Reset then `audio_in`=12'hA5C, default parameters:
  - First `sample_strobe` occurs 4999 cycles after reset release.
  - Bits captured on SCLK falling edges are 16'h0A5C.
  - `dac_sync` is low for 64 cycles.
- `PD_MODE`=2'b11, `audio_in`=12'hFFF: captured word is 16'h3FFF.
- Change `audio_in` from 12'h000 to 12'hFFF mid-frame: the current frame still carries 16'h0000, and the next frame carries 16'h0FFF.
- Set DIV=100 (`SAMPLE_HZ`=1_000_000) with `SCLK_HALF`=2:
  - Frames are back-to-back every 100 cycles.
  - `overrun` is never asserted.
- Override internal ticks to arrive every 40 cycles:
  - `overrun` pulses on ticks landing inside a frame.
  - Frames stay intact at 64 low cycles each.
- Deassert `rstn` (drive it low) at frame cycle 20, hold it 1 cycle, then release:
  - `dac_sync`=1 and `dac_sclk`=1 on the next edge.
  - No further SCLK edges occur until the next tick, DIV-1 cycles after release.
